// File: rtl/gpr_pkg.sv
// gpr_pkg -- shared defaults and types for the multi-ported register file.
//   GPR_N    : register width in bits
//   GPR_NREG : register count (power of two, >= 2)
//   GPR_NRD  : read port count
//   GPR_NWR  : write port count
package gpr_pkg;

    localparam int GPR_N    = 32;
    localparam int GPR_NREG = 32;
    localparam int GPR_NRD  = 4;
    localparam int GPR_NWR  = 2;
    localparam int GPR_K    = $clog2(GPR_NREG);

    typedef logic [GPR_N-1:0] gpr_word_t;
    typedef logic [GPR_K-1:0] gpr_addr_t;

endpackage

// File: rtl/gpr_wr_arb.sv
// gpr_wr_arb -- resolves which write port (if any) targets one address.
// The highest-indexed enabled port that matches wins. Address 0 never
// matches, because register 0 is hardwired to zero.
//   i_addr    : address being examined
//   i_wr_en   : per-port write enable
//   i_wr_addr : per-port write address
//   i_wr_data : per-port write data
//   o_hit     : at least one enabled port targets i_addr
//   o_data    : data of the winning port ('0 when no hit)
module gpr_wr_arb #(
    parameter int N   = 32,
    parameter int K   = 5,
    parameter int NWR = 2
) (
    input  logic [K-1:0]          i_addr,
    input  logic [NWR-1:0]        i_wr_en,
    input  logic [NWR-1:0][K-1:0] i_wr_addr,
    input  logic [NWR-1:0][N-1:0] i_wr_data,
    output logic                  o_hit,
    output logic [N-1:0]          o_data
);

    // Ascending scan: later (higher-index) matches overwrite earlier ones.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        for (int i = 0; i < NWR; i++) begin
            if (i_wr_en[i] && (i_wr_addr[i] == i_addr) && (i_addr != '0)) begin
                o_hit  = 1'b1;
                o_data = i_wr_data[i];
            end
        end
    end

endmodule

// File: rtl/gpr_mp.sv
// gpr_mp -- multi-ported general purpose register file with a busy
// scoreboard and write-through bypass.
//   clk, rst_n   : clock, asynchronous active-low reset
//   rd_addr      : per read port address
//   rd_data      : per read port data (combinational, bypassed)
//   rd_busy      : per read port "pending producer" flag
//   wr_en/addr/data : per write port; highest port index wins a collision
//   sb_set_en/addr  : claim a destination register as pending
// Register 0 reads 0, ignores writes and is never busy.
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int N    = GPR_N,
    parameter int NREG = GPR_NREG,
    parameter int NRD  = GPR_NRD,
    parameter int NWR  = GPR_NWR,
    localparam int K   = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD-1:0][K-1:0] rd_addr,
    output logic [NRD-1:0][N-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR-1:0][K-1:0] wr_addr,
    input  logic [NWR-1:0][N-1:0] wr_data,
    input  logic                  sb_set_en,
    input  logic [K-1:0]          sb_set_addr
);

    // Entry 0 of both arrays is reset to 0 and never written.
    logic [NREG-1:0][N-1:0] r_regs;
    logic [NREG-1:0]        r_busy;

    // Writes are masked while in reset so the bypass path also reads 0.
    logic [NWR-1:0]         w_wr_en;
    logic [NREG-1:1]        w_reg_hit;
    logic [NREG-1:1][N-1:0] w_reg_data;
    logic [NRD-1:0]         w_byp_hit;
    logic [NRD-1:0][N-1:0]  w_byp_data;
    logic [NRD-1:0]         w_set_here;

    assign w_wr_en = wr_en & {NWR{rst_n}};

    // Commit-side arbitration, one per writable register.
    for (genvar r = 1; r < NREG; r++) begin : g_reg
        gpr_wr_arb #(.N(N), .K(K), .NWR(NWR)) u_arb (
            .i_addr    (K'(r)),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_hit     (w_reg_hit[r]),
            .o_data    (w_reg_data[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (w_reg_hit[r])
                    r_regs[r] <= w_reg_data[r];
                // A claim beats a completing write to the same register.
                if (sb_set_en && (sb_set_addr == K'(r)))
                    r_busy[r] <= 1'b1;
                else if (w_reg_hit[r])
                    r_busy[r] <= 1'b0;
            end
        end
    end

    // Read ports: bypass arbitration reuses the same priority rule.
    for (genvar j = 0; j < NRD; j++) begin : g_rd
        gpr_wr_arb #(.N(N), .K(K), .NWR(NWR)) u_byp (
            .i_addr    (rd_addr[j]),
            .i_wr_en   (w_wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .o_hit     (w_byp_hit[j]),
            .o_data    (w_byp_data[j])
        );

        assign w_set_here[j] = sb_set_en && (sb_set_addr == rd_addr[j]) && (rd_addr[j] != '0);

        assign rd_data[j] = !rst_n       ? '0 :
                            w_byp_hit[j] ? w_byp_data[j] : r_regs[rd_addr[j]];

        // A bypassed write means the producer has arrived, so the port sees
        // not-busy, unless a new claim on the same register lands this cycle.
        assign rd_busy[j] = rst_n && ((w_byp_hit[j] && !w_set_here[j]) ? 1'b0
                                                                       : r_busy[rd_addr[j]]);
    end

endmodule

// File: tb/tb_gpr_mp.sv
module tb_gpr_mp;

    localparam int N    = 32;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int K    = 5;

    logic                  clk;
    logic                  rst_n;
    logic [NRD-1:0][K-1:0] rd_addr;
    logic [NRD-1:0][N-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR-1:0][K-1:0] wr_addr;
    logic [NWR-1:0][N-1:0] wr_data;
    logic                  sb_set_en;
    logic [K-1:0]          sb_set_addr;

    int n_tests = 0;
    int n_fail  = 0;

    gpr_mp #(.N(N), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_busy     (rd_busy),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en     = '0;
        sb_set_en = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        rd_addr     = '0;
        wr_en       = '0;
        wr_addr     = '0;
        wr_data     = '0;
        sb_set_en   = 1'b0;
        sb_set_addr = '0;

        // Reset: write and claim r3 while held in reset.
        rd_addr     = {5'd3, 5'd3, 5'd1, 5'd3};
        wr_en[0]    = 1'b1;
        wr_addr[0]  = 5'd3;
        wr_data[0]  = 32'h0000_1234;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd3;
        step();
        step();
        for (int j = 0; j < NRD; j++) begin
            check($sformatf("rst_data%0d", j), rd_data[j], 32'h0);
            check($sformatf("rst_busy%0d", j), {31'b0, rd_busy[j]}, 32'h0);
        end
        idle();
        rst_n = 1'b1;
        step();
        check("rst_r3_after", rd_data[0], 32'h0);
        check("rst_r3_busy_after", {31'b0, rd_busy[0]}, 32'h0);

        // Multi-write on two different registers.
        wr_en      = 2'b11;
        wr_addr[0] = 5'd5;   wr_data[0] = 32'hDEAD_BEEF;
        wr_addr[1] = 5'd10;  wr_data[1] = 32'hCAFE_BABE;
        step();
        idle();
        rd_addr = {5'd0, 5'd0, 5'd10, 5'd5};
        #1;
        check("multi_r5", rd_data[0], 32'hDEAD_BEEF);
        check("multi_r10", rd_data[1], 32'hCAFE_BABE);

        // Collision: port 1 must win.
        wr_en      = 2'b11;
        wr_addr[0] = 5'd7;  wr_data[0] = 32'h1111_1111;
        wr_addr[1] = 5'd7;  wr_data[1] = 32'h2222_2222;
        step();
        idle();
        rd_addr[2] = 5'd7;
        rd_addr[3] = 5'd5;
        #1;
        check("collide_r7", rd_data[2], 32'h2222_2222);
        check("same_addr_r5_p0", rd_data[0], 32'hDEAD_BEEF);
        check("same_addr_r5_p3", rd_data[3], 32'hDEAD_BEEF);

        // Bypass: same-cycle write visible on read port 2.
        rd_addr[2] = 5'd9;
        wr_en      = 2'b01;
        wr_addr[0] = 5'd9;  wr_data[0] = 32'hA5A5_A5A5;
        #1;
        check("bypass_r9", rd_data[2], 32'hA5A5_A5A5);
        step();
        wr_en      = 2'b00;
        wr_data[0] = 32'h1234_5678;
        #1;
        check("bypass_off_r9", rd_data[2], 32'hA5A5_A5A5);
        // Bypass collision follows port priority.
        wr_en      = 2'b11;
        wr_addr[1] = 5'd9;  wr_data[1] = 32'h0BAD_F00D;
        #1;
        check("bypass_collide_r9", rd_data[2], 32'h0BAD_F00D);
        step();
        idle();
        #1;
        check("bypass_collide_commit", rd_data[2], 32'h0BAD_F00D);

        // Scoreboard.
        rd_addr[0]  = 5'd4;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd4;
        #1;
        check("sb_claim_same_cycle", {31'b0, rd_busy[0]}, 32'h0);
        step();
        idle();
        #1;
        check("sb_busy_r4", {31'b0, rd_busy[0]}, 32'h1);
        // Write plus re-claim: stays busy.
        wr_en       = 2'b01;
        wr_addr[0]  = 5'd4;  wr_data[0] = 32'h0000_0044;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd4;
        #1;
        check("sb_set_clr_comb", {31'b0, rd_busy[0]}, 32'h1);
        step();
        idle();
        #1;
        check("sb_set_wins", {31'b0, rd_busy[0]}, 32'h1);
        check("sb_r4_data", rd_data[0], 32'h0000_0044);
        // Write alone: bypassed port sees not-busy at once, bit clears at edge.
        wr_en      = 2'b10;
        wr_addr[1] = 5'd4;  wr_data[1] = 32'h0000_0045;
        #1;
        check("sb_bypass_unbusy", {31'b0, rd_busy[0]}, 32'h0);
        step();
        idle();
        #1;
        check("sb_clear", {31'b0, rd_busy[0]}, 32'h0);
        check("sb_clear_data", rd_data[0], 32'h0000_0045);

        // Zero register.
        rd_addr[1]  = 5'd0;
        wr_en       = 2'b10;
        wr_addr[1]  = 5'd0;  wr_data[1] = 32'hFFFF_FFFF;
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd0;
        #1;
        check("r0_data_comb", rd_data[1], 32'h0);
        check("r0_busy_comb", {31'b0, rd_busy[1]}, 32'h0);
        step();
        idle();
        #1;
        check("r0_data", rd_data[1], 32'h0);
        check("r0_busy", {31'b0, rd_busy[1]}, 32'h0);

        // Mid-operation reset clears data and pending claims asynchronously.
        rd_addr     = {5'd9, 5'd5, 5'd6, 5'd6};
        sb_set_en   = 1'b1;
        sb_set_addr = 5'd6;
        step();
        idle();
        #1;
        check("pre_rst_busy_r6", {31'b0, rd_busy[0]}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy_r6", {31'b0, rd_busy[1]}, 32'h0);
        check("async_rst_r5", rd_data[2], 32'h0);
        rst_n = 1'b1;
        step();
        check("post_rst_r9", rd_data[3], 32'h0);
        check("post_rst_busy_r6", {31'b0, rd_busy[0]}, 32'h0);
        // Normal writes resume after reset.
        wr_en      = 2'b01;
        wr_addr[0] = 5'd6;  wr_data[0] = 32'h6666_6666;
        step();
        idle();
        #1;
        check("resume_r6", rd_data[0], 32'h6666_6666);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
